// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_e : bit-level deframer states
//   ps2_key_t   : {toggle, pressed, extended, code} key event payload
//   prefix/discard byte constants and the E1 (Pause) skip length
package ps2_pkg;

    localparam int unsigned CODE_W    = 8;
    localparam int unsigned KEY_W     = 11;
    localparam int unsigned BIT_IDX_W = 4;
    localparam int unsigned SKIP_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic              toggle;
        logic              pressed;
        logic              extended;
        logic [CODE_W-1:0] code;
    } ps2_key_t;

    localparam logic [CODE_W-1:0] PFX_EXT   = 8'hE0;
    localparam logic [CODE_W-1:0] PFX_BRK   = 8'hF0;
    localparam logic [CODE_W-1:0] PFX_PAUSE = 8'hE1;

    // Bytes after E1 that belong to the Pause sequence and must be swallowed
    localparam logic [SKIP_W-1:0] E1_SKIP = 3'd7;

    // Keyboard status/acknowledge bytes that never map to a key
    function automatic logic is_discard(input logic [CODE_W-1:0] b);
        logic hit;
        hit = 1'b0;
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: hit = 1'b1;
            default:                    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_line_sync.sv
// PS/2 line conditioning: double-flop synchronizers on both raw lines, a
// level filter on the clock line and a one-cycle strobe on each accepted
// 1->0 clock transition.
//   clk_sys   in  system clock
//   reset_n   in  async active-low reset
//   ps2_clk   in  raw PS/2 clock line
//   ps2_data  in  raw PS/2 data line
//   clk_fall  out 1-cycle strobe, filtered ps2_clk fell
//   data_sync out synchronized ps2_data, valid to sample with clk_fall
module ps2_key_decoder_line_sync #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_sync
);

    localparam int unsigned CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic [1:0]       clk_meta_q;
    logic [1:0]       data_meta_q;
    logic             clk_filt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fall_q;

    // cnt_q counts consecutive synced samples that disagree with the filtered
    // level; the level flips on the FILTER_LEN-th such sample.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q  <= 2'b11;
            data_meta_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_meta_q  <= {clk_meta_q[0], ps2_clk};
            data_meta_q <= {data_meta_q[0], ps2_data};
            fall_q      <= 1'b0;
            if (clk_meta_q[1] == clk_filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                clk_filt_q <= clk_meta_q[1];
                cnt_q      <= '0;
                fall_q     <= clk_filt_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign clk_fall  = fall_q;
    assign data_sync = data_meta_q[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// Host-side PS/2 keyboard receiver. Deframes 11-bit device->host frames,
// folds E0/F0/E1 prefixes and publishes a toggle-style key event bus.
//   clk_sys    in   system clock
//   reset_n    in   async active-low reset
//   ps2_clk    in   raw PS/2 clock line (idle high)
//   ps2_data   in   raw PS/2 data line (idle high)
//   ps2_key    out  {toggle, pressed, extended, code[7:0]}
//   busy       out  frame in progress
//   parity_err out  1-cycle pulse, frame dropped for even parity
//   frame_err  out  1-cycle pulse, frame dropped for bad stop bit or timeout
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 120000
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [KEY_W-1:0] ps2_key,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_fall;
    logic data_sync;

    ps2_key_decoder_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_sync (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_fall  (clk_fall),
        .data_sync (data_sync)
    );

    ps2_state_e          state_q, state_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CODE_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    ps2_key_t            key_q, key_d;
    logic                busy_q, busy_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                byte_valid_c;

    // State and output registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            to_cnt_q  <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            skip_q    <= '0;
            key_q     <= '0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            to_cnt_q  <= to_cnt_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            skip_q    <= skip_d;
            key_q     <= key_d;
            busy_q    <= busy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Bit deframer, timeout watchdog and byte/prefix layer
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        to_cnt_d     = to_cnt_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        skip_d       = skip_q;
        key_d        = key_q;
        perr_d       = 1'b0;
        ferr_d       = 1'b0;
        byte_valid_c = 1'b0;

        // Watchdog restarts on every accepted clock fall, idles outside a frame
        if (state_q == ST_IDLE || clk_fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (clk_fall && !data_sync) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (clk_fall) begin
                    shift_d = {data_sync, shift_q[CODE_W-1:1]};
                    if (bit_idx_q == BIT_IDX_W'(CODE_W - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (clk_fall) begin
                    parity_d = data_sync;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fall) begin
                    state_d = ST_IDLE;
                    if (!data_sync) begin
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (!(^{shift_q, parity_q})) begin
                        perr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else begin
                        byte_valid_c = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stalled frame: abandon the byte but keep any prefix already folded
        if (state_q != ST_IDLE && !clk_fall && to_cnt_d == TO_W'(TIMEOUT_CYCLES)) begin
            state_d  = ST_IDLE;
            ferr_d   = 1'b1;
            to_cnt_d = '0;
        end

        if (byte_valid_c) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 1'b1;
            end else if (shift_q == PFX_PAUSE) begin
                skip_d = E1_SKIP;
            end else if (shift_q == PFX_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PFX_BRK) begin
                brk_d = 1'b1;
            end else if (!is_discard(shift_q)) begin
                key_d.toggle   = ~key_q.toggle;
                key_d.pressed  = ~brk_q;
                key_d.extended = ext_q;
                key_d.code     = shift_q;
                ext_d          = 1'b0;
                brk_d          = 1'b0;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign ps2_key    = key_q;
    assign busy       = busy_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed PS/2 scenarios with literal expectations
// followed by randomized frames, all checked against a byte-level model.
module tb_ps2_key_decoder;

    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned TIMEOUT    = 400;
    localparam int          HALF       = 16;
    localparam int          SETTLE     = 12;

    logic        clk_sys  = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        busy;
    logic        parity_err;
    logic        frame_err;

    ps2_key_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_key    (ps2_key),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #10 clk_sys = ~clk_sys;

    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;
    longint settle_until = 0;
    bit     checking    = 1'b0;
    int     seen_perr   = 0;
    int     seen_ferr   = 0;

    // Byte-level reference model
    logic [10:0] m_key  = '0;
    bit          m_ext  = 1'b0;
    bit          m_brk  = 1'b0;
    int          m_skip = 0;
    bit          m_busy = 1'b0;
    int          m_perr = 0;
    int          m_ferr = 0;

    logic [7:0] disc_codes [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Per-cycle comparison of the steady outputs; error pulses are tallied
    always @(negedge clk_sys) begin
        cyc++;
        if (parity_err === 1'b1) seen_perr++;
        if (frame_err === 1'b1)  seen_ferr++;
        if (checking && cyc > settle_until) begin
            check("ps2_key", 32'(ps2_key), 32'(m_key));
            check("busy", 32'(busy), 32'(m_busy));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: bench did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_stop) begin
            m_ferr++; m_ext = 1'b0; m_brk = 1'b0;
        end else if (bad_par) begin
            m_perr++; m_ext = 1'b0; m_brk = 1'b0;
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Present one bit while clock is high, then pull clock low (left low)
    task automatic drive_fall(input logic b, input bit glitch);
        @(negedge clk_sys);
        ps2_data = b;
        if (glitch) begin
            wait_cycles(HALF / 2);
            ps2_clk = 1'b0;
            @(negedge clk_sys);
            ps2_clk = 1'b1;
            wait_cycles(HALF / 2);
        end else begin
            wait_cycles(HALF);
        end
        ps2_clk = 1'b0;
    endtask

    task automatic release_clk();
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic check_counts();
        check("parity_err pulses", 32'(seen_perr), 32'(m_perr));
        check("frame_err pulses", 32'(seen_ferr), 32'(m_ferr));
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        logic par;
        par = (~^b) ^ bad_par;
        drive_fall(1'b0, 1'b0);
        settle_until = cyc + SETTLE;
        m_busy = 1'b1;
        release_clk();
        for (int i = 0; i < 8; i++) begin
            drive_fall(b[i], glitch && (i == 3));
            release_clk();
        end
        drive_fall(par, 1'b0);
        release_clk();
        drive_fall(~bad_stop, 1'b0);
        settle_until = cyc + SETTLE;
        m_busy = 1'b0;
        model_byte(b, bad_par, bad_stop);
        release_clk();
        @(negedge clk_sys);
        ps2_data = 1'b1;
        wait_cycles(20 + $urandom_range(0, 20));
        check_counts();
    endtask

    // Start bit plus (nfalls-1) further bits, then the clock goes quiet
    task automatic send_partial(input logic [7:0] b, input int nfalls);
        logic [10:0] bits;
        bits = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < nfalls; i++) begin
            drive_fall(bits[i], 1'b0);
            if (i == 0) begin
                settle_until = cyc + SETTLE;
                m_busy = 1'b1;
            end
            release_clk();
        end
        @(negedge clk_sys);
        ps2_data = 1'b1;
    endtask

    task automatic expect_timeout();
        wait_cycles(TIMEOUT - HALF - 40);
        settle_until = cyc + 80;
        m_busy = 1'b0;
        m_ferr++;
        wait_cycles(90);
        check_counts();
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        settle_until = cyc + SETTLE + 3;
        reset_n = 1'b0;
        m_key = '0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; m_busy = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(SETTLE + 2);
    endtask

    initial begin
        wait_cycles(5);
        reset_n = 1'b1;
        wait_cycles(3);
        checking = 1'b1;
        check("reset ps2_key", 32'(ps2_key), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset parity_err", 32'(parity_err), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);

        // Plain make code
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        check("make 29", 32'(ps2_key), 32'h629);
        // Break prefix: nothing on F0, one event on 29
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        check("F0 alone", 32'(ps2_key), 32'h629);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        check("break 29", 32'(ps2_key), 32'h029);
        // Extended make, extended break, then ext must be cleared
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        check("ext make 75", 32'(ps2_key), 32'h775);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        check("ext break 75", 32'(ps2_key), 32'h175);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("make 1C", 32'(ps2_key), 32'h61C);
        // Parity error drops the byte
        send_frame(8'h29, 1'b1, 1'b0, 1'b0);
        check("parity drop", 32'(ps2_key), 32'h61C);
        check("parity pulse count", 32'(seen_perr), 32'd1);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("after parity err", 32'(ps2_key), 32'h21C);
        // Clock stops mid-frame
        send_partial(8'h16, 5);
        expect_timeout();
        check("timeout pulse count", 32'(seen_ferr), 32'd1);
        send_frame(8'h16, 1'b0, 1'b0, 1'b0);
        check("after timeout", 32'(ps2_key), 32'h616);
        // Pause sequence yields no events
        foreach (disc_codes[i]) if (i < 0) ;
        begin
            logic [7:0] pause_seq [8];
            pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0, 1'b0, 1'b0);
        end
        check("pause silent", 32'(ps2_key), 32'h616);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        check("after pause", 32'(ps2_key), 32'h229);
        // Reset clears a pending break prefix
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("reset clears key", 32'(ps2_key), 32'h0);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        check("make after reset", 32'(ps2_key), 32'h629);
        // Status bytes are discarded
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFA, 1'b0, 1'b0, 1'b0);
        check("discard AA FA", 32'(ps2_key), 32'h629);
        // Single-sample clock glitch with data low in idle must not start a frame
        @(negedge clk_sys);
        ps2_data = 1'b0;
        wait_cycles(4);
        ps2_clk = 1'b0;
        @(negedge clk_sys);
        ps2_clk = 1'b1;
        wait_cycles(4);
        ps2_data = 1'b1;
        wait_cycles(20);
        check("glitch no busy", 32'(busy), 32'h0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("after glitch", 32'(ps2_key), 32'h21C);

        // Randomized traffic
        for (int n = 0; n < 100; n++) begin
            int r;
            int mode;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 10)      b = 8'hE0;
            else if (r < 20) b = 8'hF0;
            else if (r < 23) b = 8'hE1;
            else if (r < 30) b = disc_codes[$urandom_range(0, 7)];
            else             b = 8'($urandom_range(0, 255));
            mode = $urandom_range(0, 99);
            if (mode < 4) begin
                send_partial(b, $urandom_range(1, 10));
                expect_timeout();
            end else if (mode < 7) begin
                send_partial(b, $urandom_range(1, 10));
                do_reset();
                check_counts();
            end else begin
                send_frame(b, (mode >= 7 && mode < 13), (mode >= 13 && mode < 17),
                           ($urandom_range(0, 9) == 0));
            end
        end

        wait_cycles(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
